cdb_arbiter: RTL and testbench

Buffers results from the ALU and the load/store buffer and shares a single common data bus (CDB) between them, one broadcast per cycle. It sits between the execution units and every CDB consumer (reservation station, LSB, ROB). Its consumers snoop one tag/value pair instead of two. Round-robin arbitration, per-source FIFOs, issue back-pressure toward the reservation station, and misprediction flush are handled here.

---
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter.sv | 116 +++++++++++
 tb/tb_cdb_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result and broadcast signals shared by the execution units and the CDB arbiter.
// master: producer/consumer side; slave: the arbiter.
interface cdb_arbiter_if #(
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  rdy;
  logic                  in_clear;
  logic [TAG_WIDTH-1:0]  in_alu_tag;
  logic [DATA_WIDTH-1:0] in_alu_value;
  logic [TAG_WIDTH-1:0]  in_lsb_tag;
  logic [DATA_WIDTH-1:0] in_lsb_value;
  logic                  out_alu_hold;
  logic                  out_lsb_hold;
  logic [TAG_WIDTH-1:0]  out_cdb_tag;
  logic [DATA_WIDTH-1:0] out_cdb_value;
  logic                  out_overflow;

  modport master (
    output rdy, in_clear, in_alu_tag, in_alu_value, in_lsb_tag, in_lsb_value,
    input  out_alu_hold, out_lsb_hold, out_cdb_tag, out_cdb_value, out_overflow
  );

  modport slave (
    input  rdy, in_clear, in_alu_tag, in_alu_value, in_lsb_tag, in_lsb_value,
    output out_alu_hold, out_lsb_hold, out_cdb_tag, out_cdb_value, out_overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Buffers ALU and LSB results in per-source FIFOs and round-robins them onto one CDB.
// Define CDB_ARBITER_BYPASS_EN to let an empty FIFO's live input compete the same cycle.
module cdb_arbiter #(
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = TAG_WIDTH + DATA_WIDTH;
  localparam int ALU = 0;
  localparam int LSB = 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
  // One slot of slack covers the result already in flight behind a registered issue.
  localparam logic [CW-1:0] HOLD_LVL = CW'(FIFO_DEPTH - 1);

  logic [EW-1:0]         mem [2][FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr [2];
  logic [PW-1:0]         wr_ptr [2];
  logic [CW-1:0]         cnt [2];
  logic                  last_grant;   // 1 = LSB granted most recently
  logic [TAG_WIDTH-1:0]  cdb_tag_p1;
  logic [DATA_WIDTH-1:0] cdb_value_p1;
  logic                  overflow;

  logic [EW-1:0] in_ent_p0 [2];
  logic [EW-1:0] head_p0 [2];
  logic [EW-1:0] cand_p0 [2];
  logic [EW-1:0] win_p0;
  logic [1:0]    in_vld_p0, head_vld_p0, cand_vld_p0, gnt_p0;
  logic [1:0]    pop_p0, byp_p0, acc_p0, drop_p0;

  // Stage p0: candidate selection, arbitration and FIFO push/pop decisions
  always_comb begin
    in_ent_p0[ALU] = {bus.in_alu_tag, bus.in_alu_value};
    in_ent_p0[LSB] = {bus.in_lsb_tag, bus.in_lsb_value};
    in_vld_p0      = {bus.in_lsb_tag != '0, bus.in_alu_tag != '0};
    for (int s = 0; s < 2; s++) begin
      head_vld_p0[s] = cnt[s] != '0;
      head_p0[s]     = mem[s][rd_ptr[s]];
`ifdef CDB_ARBITER_BYPASS_EN
      cand_vld_p0[s] = head_vld_p0[s] | in_vld_p0[s];
      cand_p0[s]     = head_vld_p0[s] ? head_p0[s] : in_ent_p0[s];
`else
      cand_vld_p0[s] = head_vld_p0[s];
      cand_p0[s]     = head_p0[s];
`endif
    end
    gnt_p0[ALU] = cand_vld_p0[ALU] & (~cand_vld_p0[LSB] | last_grant);
    gnt_p0[LSB] = cand_vld_p0[LSB] & (~cand_vld_p0[ALU] | ~last_grant);
    win_p0      = gnt_p0[LSB] ? cand_p0[LSB] : cand_p0[ALU];
    for (int s = 0; s < 2; s++) begin
      pop_p0[s]  = gnt_p0[s] & head_vld_p0[s];
      byp_p0[s]  = gnt_p0[s] & ~head_vld_p0[s];
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
      acc_p0[s]  = in_vld_p0[s] & ~byp_p0[s] & ((cnt[s] != FULL_LVL) | pop_p0[s]);
      drop_p0[s] = in_vld_p0[s] & ~byp_p0[s] & (cnt[s] == FULL_LVL) & ~pop_p0[s];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.rdy && !bus.in_clear) begin
      for (int s = 0; s < 2; s++) begin
        if (acc_p0[s]) mem[s][wr_ptr[s]] <= in_ent_p0[s];
      end
    end
  end

  // Stage p1: registered broadcast and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      last_grant   <= 1'b1;
      cdb_tag_p1   <= '0;
      cdb_value_p1 <= '0;
      overflow     <= 1'b0;
    end else if (bus.rdy) begin
      if (bus.in_clear) begin
        for (int s = 0; s < 2; s++) begin
          rd_ptr[s] <= '0;
          wr_ptr[s] <= '0;
          cnt[s]    <= '0;
        end
        cdb_tag_p1 <= '0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (acc_p0[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
          if (pop_p0[s]) rd_ptr[s] <= rd_ptr[s] + PW'(1);
          cnt[s] <= cnt[s] + CW'(acc_p0[s]) - CW'(pop_p0[s]);
        end
        if (gnt_p0 != 2'b00) begin
          cdb_tag_p1   <= win_p0[EW-1 -: TAG_WIDTH];
          cdb_value_p1 <= win_p0[DATA_WIDTH-1:0];
          last_grant   <= gnt_p0[LSB];
        end else begin
          cdb_tag_p1 <= '0;
        end
        if (drop_p0 != 2'b00) overflow <= 1'b1;
      end
    end
  end

  assign bus.out_cdb_tag   = cdb_tag_p1;
  assign bus.out_cdb_value = cdb_value_p1;
  assign bus.out_overflow  = overflow;
  assign bus.out_alu_hold  = cnt[ALU] >= HOLD_LVL;
  assign bus.out_lsb_hold  = cnt[LSB] >= HOLD_LVL;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand sequences, and randomized
// stimulus checked against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int TW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef CDB_ARBITER_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW)) bus ();
  cdb_arbiter #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, arbitration from the round-robin rule.
  logic [TW+DW-1:0] m_qa[$];
  logic [TW+DW-1:0] m_ql[$];
  bit               m_lg;     // 1 = LSB granted last
  logic [TW-1:0]    m_tag;
  logic [DW-1:0]    m_val;
  bit               m_ovf;

  function automatic void model_step(input bit r, input bit rd, input bit clr,
                                     input logic [TW-1:0] at, input logic [DW-1:0] av,
                                     input logic [TW-1:0] lt, input logic [DW-1:0] lv);
    bit ca, cl, ba, bl;
    int g;
    logic [TW+DW-1:0] e;
    if (r) begin
      m_qa.delete(); m_ql.delete();
      m_lg = 1; m_tag = '0; m_val = '0; m_ovf = 0;
      return;
    end
    if (!rd) return;
    if (clr) begin
      m_qa.delete(); m_ql.delete();
      m_tag = '0;
      return;
    end
    ca = m_qa.size() > 0; cl = m_ql.size() > 0; ba = 0; bl = 0;
`ifdef CDB_ARBITER_BYPASS_EN
    if (!ca && at != 0) begin ca = 1; ba = 1; end
    if (!cl && lt != 0) begin cl = 1; bl = 1; end
`endif
    g = -1;
    if (ca && cl) g = m_lg ? 0 : 1;
    else if (ca)  g = 0;
    else if (cl)  g = 1;
    if (g == 0) begin
      e = ba ? {at, av} : m_qa.pop_front();
      m_lg = 0;
    end else if (g == 1) begin
      e = bl ? {lt, lv} : m_ql.pop_front();
      m_lg = 1;
    end
    if (g >= 0) begin
      m_tag = e[TW+DW-1:DW];
      m_val = e[DW-1:0];
    end else begin
      m_tag = '0;
    end
    if (at != 0 && !(g == 0 && ba)) begin
      if (m_qa.size() < DEPTH) m_qa.push_back({at, av}); else m_ovf = 1;
    end
    if (lt != 0 && !(g == 1 && bl)) begin
      if (m_ql.size() < DEPTH) m_ql.push_back({lt, lv}); else m_ovf = 1;
    end
  endfunction

  task automatic cycle(input bit r, input bit rd, input bit clr,
                       input logic [TW-1:0] at, input logic [DW-1:0] av,
                       input logic [TW-1:0] lt, input logic [DW-1:0] lv);
    rst = r; bus.rdy = rd; bus.in_clear = clr;
    bus.in_alu_tag = at; bus.in_alu_value = av;
    bus.in_lsb_tag = lt; bus.in_lsb_value = lv;
    @(posedge clk);
    model_step(r, rd, clr, at, av, lt, lv);
    #1;
    chk("cdb_tag", 64'(bus.out_cdb_tag), 64'(m_tag));
    if (m_tag != 0 || r) chk("cdb_value", 64'(bus.out_cdb_value), 64'(m_val));
    chk("overflow", 64'(bus.out_overflow), 64'(m_ovf));
    chk("alu_hold", 64'(bus.out_alu_hold), 64'(m_qa.size() >= DEPTH - 1));
    chk("lsb_hold", 64'(bus.out_lsb_hold), 64'(m_ql.size() >= DEPTH - 1));
  endtask

  typedef struct {
    bit            r, rd, clr;
    logic [TW-1:0] at;
    logic [DW-1:0] av;
    logic [TW-1:0] lt;
    logic [DW-1:0] lv;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_val;
    bit            e_ovf, e_ah, e_lh;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit r, input bit rd, input bit clr,
                              input logic [TW-1:0] at, input logic [DW-1:0] av,
                              input logic [TW-1:0] lt, input logic [DW-1:0] lv,
                              input logic [TW-1:0] et, input logic [DW-1:0] ev,
                              input bit eo, input bit eah, input bit elh);
    vec_t v;
    v.r = r; v.rd = rd; v.clr = clr; v.at = at; v.av = av; v.lt = lt; v.lv = lv;
    v.e_tag = et; v.e_val = ev; v.e_ovf = eo; v.e_ah = eah; v.e_lh = elh;
    tbl.push_back(v);
  endfunction

  initial begin
    int lat, occ;
    m_lg = 1; m_tag = '0; m_val = '0; m_ovf = 0;

    // single result, then a same-cycle conflict (ALU wins the first one)
    add(1,1,0,  0,0,       0,0,       0,0,       0,0,0);
    add(0,1,0,  3,'h11,    0,0,       0,0,       0,0,0);
    add(0,1,0,  0,0,       0,0,       3,'h11,    0,0,0);
    add(0,1,0,  0,0,       0,0,       0,0,       0,0,0);
    add(1,1,0,  0,0,       0,0,       0,0,       0,0,0);
    add(0,1,0,  1,'h101,   2,'h202,   0,0,       0,0,0);
    add(0,1,0,  0,0,       0,0,       1,'h101,   0,0,0);
    add(0,1,0,  0,0,       0,0,       2,'h202,   0,0,0);
    add(0,1,0,  0,0,       0,0,       0,0,       0,0,0);
    // fill ALU FIFO under contention: full+pop accepted, then full without pop drops 13
    add(0,1,0,  1,'h101,   2,'h202,   0,0,       0,0,0);
    add(0,1,0,  3,'h103,   4,'h204,   1,'h101,   0,0,0);
    add(0,1,0,  5,'h105,   6,'h206,   2,'h202,   0,0,0);
    add(0,1,0,  7,'h107,   8,'h208,   3,'h103,   0,0,1);
    add(0,1,0,  9,'h109,   0,0,       4,'h204,   0,1,0);
    add(0,1,0, 10,'h10a,   0,0,       5,'h105,   0,1,0);
    add(0,1,0, 11,'h10b,   0,0,       6,'h206,   0,1,0);
    add(0,1,0, 12,'h10c,   0,0,       7,'h107,   0,1,0);
    add(0,1,0, 13,'h10d,   0,0,       8,'h208,   1,1,0);
    add(0,1,0,  0,0,       0,0,       9,'h109,   1,1,0);
    add(0,1,0,  0,0,       0,0,      10,'h10a,   1,0,0);
    add(0,1,0,  0,0,       0,0,      11,'h10b,   1,0,0);
    add(0,1,0,  0,0,       0,0,      12,'h10c,   1,0,0);
    add(0,1,0,  0,0,       0,0,       0,0,       1,0,0);
    // queue three ALU results, then clear with fresh inputs present
    add(0,1,0,  1,'h101,   2,'h202,   0,0,       1,0,0);
    add(0,1,0,  3,'h103,   4,'h204,   2,'h202,   1,0,0);
    add(0,1,0,  5,'h105,   6,'h206,   1,'h101,   1,0,0);
    add(0,1,0,  7,'h107,   0,0,       4,'h204,   1,1,0);
    add(0,1,1,  8,'h108,   9,'h209,   0,0,       1,0,0);
    add(0,1,0,  0,0,       0,0,       0,0,       1,0,0);
    add(0,1,0, 10,'h10a,   0,0,       0,0,       1,0,0);
    add(0,1,0,  0,0,       0,0,      10,'h10a,   1,0,0);
    add(0,1,0,  0,0,       0,0,       0,0,       1,0,0);
    // rdy low freezes everything and ignores inputs
    add(1,1,0,  0,0,       0,0,       0,0,       0,0,0);
    add(0,1,0,  3,'h103,   0,0,       0,0,       0,0,0);
    add(0,1,0,  4,'h104,   0,0,       3,'h103,   0,0,0);
    for (int k = 0; k < 5; k++)
      add(0,0,0, 5,'h105,  6,'h206,   3,'h103,   0,0,0);
    add(0,1,0,  0,0,       0,0,       4,'h104,   0,0,0);
    add(0,1,0,  0,0,       0,0,       0,0,       0,0,0);

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].rd, tbl[i].clr, tbl[i].at, tbl[i].av, tbl[i].lt, tbl[i].lv);
`ifndef CDB_ARBITER_BYPASS_EN
      chk($sformatf("vec%0d_tag", i), 64'(bus.out_cdb_tag), 64'(tbl[i].e_tag));
      if (tbl[i].e_tag != 0 || tbl[i].r)
        chk($sformatf("vec%0d_val", i), 64'(bus.out_cdb_value), 64'(tbl[i].e_val));
      chk($sformatf("vec%0d_ovf", i), 64'(bus.out_overflow), 64'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_ahold", i), 64'(bus.out_alu_hold), 64'(tbl[i].e_ah));
      chk($sformatf("vec%0d_lhold", i), 64'(bus.out_lsb_hold), 64'(tbl[i].e_lh));
`endif
    end

    // first-result latency and single broadcast, bounded to 8 cycles
    cycle(1,1,0, 0,0, 0,0);
    lat = 0; occ = 0;
    cycle(0,1,0, 5,'h55, 0,0);
    if (bus.out_cdb_tag == 5) begin occ++; lat = 1; end
    for (int k = 2; k <= 8; k++) begin
      cycle(0,1,0, 0,0, 0,0);
      if (bus.out_cdb_tag == 5) begin occ++; if (lat == 0) lat = k; end
    end
    chk("first_latency", 64'(lat), 64'(EXP_LAT));
    chk("broadcast_once", 64'(occ), 64'd1);

    // reset in the middle of queued traffic
    cycle(0,1,0, 1,'h1, 2,'h2);
    cycle(0,1,0, 3,'h3, 4,'h4);
    cycle(0,1,0, 5,'h5, 6,'h6);
    cycle(1,1,0, 7,'h7, 8,'h8);
    for (int k = 0; k < 4; k++) cycle(0,1,0, 0,0, 0,0);

    // random traffic from producers that honour hold: no overflow may occur
    cycle(1,1,0, 0,0, 0,0);
    for (int i = 0; i < 1500; i++) begin
      logic [TW-1:0] at, lt;
      at = (!bus.out_alu_hold && $urandom_range(0,2) != 0) ? TW'($urandom_range(1,15)) : '0;
      lt = (!bus.out_lsb_hold && $urandom_range(0,2) != 0) ? TW'($urandom_range(1,15)) : '0;
      cycle(0, $urandom_range(0,9) != 0, 0, at, $urandom, lt, $urandom);
    end
    chk("honored_hold_no_overflow", 64'(bus.out_overflow), 64'd0);

    // unrestricted random traffic with clears, stalls and resets
    for (int i = 0; i < 1500; i++) begin
      logic [TW-1:0] at, lt;
      at = ($urandom_range(0,9) < 3) ? '0 : TW'($urandom_range(1,15));
      lt = ($urandom_range(0,9) < 3) ? '0 : TW'($urandom_range(1,15));
      cycle($urandom_range(0,199) == 0, $urandom_range(0,6) != 0,
            $urandom_range(0,29) == 0, at, $urandom, lt, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
